// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: frame-aligned start/stop, h/v phase FSMs, registered sync/DE/coords.
// Optional VGA_FRAME_CNT_EN adds frame_cnt_o and underrun_o.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW       = $clog2(H_TOTAL),
    localparam int unsigned YW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    output logic          busy_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]   frame_cnt_o,
    output logic          underrun_o,
`endif
    output logic          frame_start_o
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_param
        $error("vga_timing_ctrl: all timing parameters must be non-zero");
    end

    localparam logic [XW-1:0] HFpStart   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HSyncStart = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HBpStart   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] XLast      = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] VFpStart   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VSyncStart = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VBpStart   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] YLast      = YW'(V_TOTAL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
    typedef enum logic [1:0] {PhActive, PhFp, PhSync, PhBp} phase_e;

    state_e          state_q, state_d;
    phase_e          h_ph_q, h_ph_d, v_ph_q, v_ph_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            busy_q, busy_d, hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic            ls_q, ls_d, fs_q, fs_d;
    logic            x_wrap, last_px, active_d;

    assign x_wrap  = (x_q == XLast);
    assign last_px = x_wrap && (y_q == YLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            h_ph_q  <= PhActive;
            v_ph_q  <= PhActive;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_ph_q  <= h_ph_d;
            v_ph_q  <= v_ph_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    // Stop requests only take effect at the end of the current frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   if (!en_i) state_d = last_px ? StIdle : StDrain;
            StDrain: begin
                if (en_i)         state_d = StRun;
                else if (last_px) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters and phases are computed for the pixel shown next cycle, so all outputs align.
    always_comb begin
        x_d = '0;
        y_d = '0;
        if (state_q != StIdle && state_d != StIdle) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            y_d = y_q;
            if (x_wrap) y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
        end

        h_ph_d = h_ph_q;
        if (x_d == '0)              h_ph_d = PhActive;
        else if (x_d == HFpStart)   h_ph_d = PhFp;
        else if (x_d == HSyncStart) h_ph_d = PhSync;
        else if (x_d == HBpStart)   h_ph_d = PhBp;

        v_ph_d = v_ph_q;
        if (x_d == '0) begin
            if (y_d == '0)              v_ph_d = PhActive;
            else if (y_d == VFpStart)   v_ph_d = PhFp;
            else if (y_d == VSyncStart) v_ph_d = PhSync;
            else if (y_d == VBpStart)   v_ph_d = PhBp;
        end
    end

    always_comb begin
        active_d = (state_d != StIdle);
        busy_d   = active_d;
        de_d     = active_d && (h_ph_d == PhActive) && (v_ph_d == PhActive);
        hsync_d  = (active_d && h_ph_d == PhSync) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (active_d && v_ph_d == PhSync) ? VSYNC_POL : ~VSYNC_POL;
        ls_d     = active_d && (x_d == '0);
        fs_d     = ls_d && (y_d == '0);
    end

    assign busy_o        = busy_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = ls_q;
    assign frame_start_o = fs_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        underrun_q, underrun_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    // The frame that leaves IDLE is not counted; only frames that follow a running one.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (fs_d && state_q != StIdle) frame_cnt_d = frame_cnt_q + 16'd1;
        underrun_d = (state_q == StRun) && !en_i && (y_q < VFpStart);
    end

    assign frame_cnt_o = frame_cnt_q;
    assign underrun_o  = underrun_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a small 16x12 timing so whole frames fit in the run.
module tb_vga_timing_ctrl;
    localparam int unsigned HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int unsigned VA = 6, VFP = 2, VS = 2, VBP = 2;
    localparam int unsigned HT = 16, VT = 12, FRAME = HT * VT;
    localparam bit          HPOL = 1'b1, VPOL = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       busy, hsync, vsync, de, ls, fs;
    logic [3:0] x, y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        underrun;
`endif

    int errors = 0;
    int checks = 0;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .busy_o       (busy),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .de_o         (de),
        .x_o          (x),
        .y_o          (y),
        .line_start_o (ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt_o  (frame_cnt),
        .underrun_o   (underrun),
`endif
        .frame_start_o(fs)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".busy"}, 32'(busy), 0);
        check_val({tag, ".de"}, 32'(de), 0);
        check_val({tag, ".x"}, 32'(x), 0);
        check_val({tag, ".y"}, 32'(y), 0);
        check_val({tag, ".ls"}, 32'(ls), 0);
        check_val({tag, ".fs"}, 32'(fs), 0);
        check_val({tag, ".hs"}, 32'(hsync), 32'(!HPOL));
        check_val({tag, ".vs"}, 32'(vsync), 32'(!VPOL));
    endtask

    // idx counts pixels since the frame-aligned start; expected values come from x/y arithmetic.
    task automatic check_pixel(input int idx);
        int  px = idx % FRAME;
        int  ex = px % HT;
        int  ey = px / HT;
        bit  hs_on = (ex >= HA + HFP) && (ex < HA + HFP + HS);
        bit  vs_on = (ey >= VA + VFP) && (ey < VA + VFP + VS);
        string t = $sformatf("px%0d", idx);
        check_val({t, ".busy"}, 32'(busy), 1);
        check_val({t, ".x"}, 32'(x), 32'(ex));
        check_val({t, ".y"}, 32'(y), 32'(ey));
        check_val({t, ".de"}, 32'(de), 32'((ex < HA) && (ey < VA)));
        check_val({t, ".hs"}, 32'(hsync), 32'(hs_on ? HPOL : !HPOL));
        check_val({t, ".vs"}, 32'(vsync), 32'(vs_on ? VPOL : !VPOL));
        check_val({t, ".ls"}, 32'(ls), 32'(ex == 0));
        check_val({t, ".fs"}, 32'(fs), 32'(px == 0));
    endtask

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");

        // en held through reset: two full frames back to back
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            check_pixel(i);
        end

        // stop request at (x=5, y=3): frame drains to the end, then idle
        for (int i = 2 * FRAME; i < 3 * FRAME; i++) begin
            @(negedge clk);
            check_pixel(i);
            if (i % FRAME == 3 * HT + 5) en = 1'b0;
        end
        @(negedge clk);
        check_idle("drained");
        repeat (3) @(negedge clk);
        check_idle("idle_hold");

        // restart, drop en at y=2 and raise it at y=4: no gap, no extra frame start
        en = 1'b1;
        for (int i = 0; i < FRAME + 5 * HT + 3; i++) begin
            @(negedge clk);
            check_pixel(i);
            if (i == 2 * HT + 3) en = 1'b0;
            if (i == 4 * HT + 7) en = 1'b1;
        end

        // reset mid-frame, then restart from the origin
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
`ifdef VGA_FRAME_CNT_EN
        check_val("frame_cnt", 32'(frame_cnt), 0);
`endif
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_reset");
        en = 1'b1;
        for (int i = 0; i < 2 * HT; i++) begin
            @(negedge clk);
            check_pixel(i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
